// File: rtl/sync_cnt_pkg.sv
// Shared types and helpers for the parametrised synchronous counter family.
// Optional build macro: SYNC_CNT_GRAY_OUT_EN (adds a registered Gray-code output).
package sync_cnt_pkg;

    typedef enum logic {
        CNT_DN = 1'b0,
        CNT_UP = 1'b1
    } cnt_dir_e;

    function automatic logic [31:0] bin2gray(input logic [31:0] value);
        return value ^ (value >> 1);
    endfunction

    // Highest value the counter may hold for a given modulus.
    function automatic int term_val(input int modulus);
        return modulus - 1;
    endfunction

endpackage

// File: rtl/sync_cnt_next.sv
// Combinational next-state and terminal-count logic for sync_cnt_param.
// Honours load > step > hold; clamps out-of-range loads to the terminal value.
module sync_cnt_next
    import sync_cnt_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 2**WIDTH,
    parameter int SATURATE = 0
) (
    input  logic [WIDTH-1:0] cnt_i,
    input  logic             up_dn_i,
    input  logic             step_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] nxt_o,
    output logic             tc_o,
    output logic             at_limit_o
);

    localparam logic [WIDTH-1:0] TERM  = WIDTH'(term_val(MODULUS));
    // One extra bit so MODULUS == 2**WIDTH is representable in the compare.
    localparam logic [WIDTH:0]   MOD_X = (WIDTH+1)'(MODULUS);

    cnt_dir_e dir;
    logic     over;

    assign dir        = cnt_dir_e'(up_dn_i);
    assign tc_o       = (dir == CNT_UP) ? (cnt_i == TERM) : (cnt_i == '0);
    assign over       = ({1'b0, load_val_i} >= MOD_X);
    assign at_limit_o = step_i & ~load_i & tc_o;

    always_comb begin
        nxt_o = cnt_i;
        if (load_i) begin
            nxt_o = over ? TERM : load_val_i;
        end else if (step_i) begin
            if (dir == CNT_UP) begin
                if (tc_o) nxt_o = (SATURATE != 0) ? cnt_i : '0;
                else      nxt_o = cnt_i + 1'b1;
            end else begin
                if (tc_o) nxt_o = (SATURATE != 0) ? cnt_i : TERM;
                else      nxt_o = cnt_i - 1'b1;
            end
        end
    end

endmodule

// File: rtl/sync_cnt_param.sv
// Parametrised cascadable up/down counter with load, wrap/saturate ends and a wrap event pulse.
// Optional build macro: SYNC_CNT_GRAY_OUT_EN adds cnt_gray_o, the registered Gray code of cnt_o.
module sync_cnt_param
    import sync_cnt_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MODULUS   = 2**WIDTH,
    parameter int SATURATE  = 0,
    parameter int RESET_VAL = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             cin_i,
    input  logic             up_dn_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             tc_o,
    output logic             co_o,
    output logic             wrap_o
`ifdef SYNC_CNT_GRAY_OUT_EN
    ,
    output logic [WIDTH-1:0] cnt_gray_o
`endif
);

    if (WIDTH < 1) begin : g_bad_width
        $error("sync_cnt_param: WIDTH must be >= 1");
    end
    if (MODULUS < 2 || MODULUS > 2**WIDTH) begin : g_bad_mod
        $error("sync_cnt_param: MODULUS must be in 2..2**WIDTH");
    end
    if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_rst
        $error("sync_cnt_param: RESET_VAL must be < MODULUS");
    end

    localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] cnt_d, cnt_q;
    logic             wrap_d, wrap_q;
    logic             step, tc, at_limit;

    assign step = en_i & cin_i;

    sync_cnt_next #(
        .WIDTH    (WIDTH),
        .MODULUS  (MODULUS),
        .SATURATE (SATURATE)
    ) u_next (
        .cnt_i      (cnt_q),
        .up_dn_i    (up_dn_i),
        .step_i     (step),
        .load_i     (load_i),
        .load_val_i (load_val_i),
        .nxt_o      (cnt_d),
        .tc_o       (tc),
        .at_limit_o (at_limit)
    );

    // A step taken at the terminal value flags a wrap, whether it wrapped or held.
    assign wrap_d = at_limit;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_q  <= RST_CNT;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign wrap_o = wrap_q;
    assign tc_o   = tc;
    assign co_o   = tc & en_i & cin_i & ~load_i;

`ifdef SYNC_CNT_GRAY_OUT_EN
    localparam logic [WIDTH-1:0] RST_GRAY = WIDTH'(bin2gray(32'(RESET_VAL)));

    logic [WIDTH-1:0] gray_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) gray_q <= RST_GRAY;
        else        gray_q <= WIDTH'(bin2gray(32'(cnt_d)));
    end

    assign cnt_gray_o = gray_q;
`endif

endmodule

// File: tb/tb_sync_cnt_param.sv
// Self-checking bench for sync_cnt_param: directed plan checks plus randomized traffic
// compared every cycle against an arithmetic model of three counters and a two-stage cascade.
module tb_sync_cnt_param;

    logic clk = 1'b1;
    always #5 clk = ~clk;

    logic       rst, en, cin, up, load;
    logic [3:0] lv;

    logic [3:0] d_cnt [3];
    logic [2:0] d_tc, d_co, d_wrap;
    logic [3:0] lo_cnt, hi_cnt;
    logic       lo_tc, hi_tc, lo_co, hi_co, lo_wrap, hi_wrap;
`ifdef SYNC_CNT_GRAY_OUT_EN
    logic [3:0] d_gray [3];
    logic [3:0] lo_gray, hi_gray;
`endif

    localparam int MODS [3] = '{16, 10, 16};
    localparam int SATS [3] = '{0, 0, 1};
    localparam int RVS  [3] = '{3, 0, 0};

    sync_cnt_param #(.WIDTH(4), .MODULUS(16), .SATURATE(0), .RESET_VAL(3)) u_a (
        .clk_i(clk), .rst_i(rst), .en_i(en), .cin_i(cin), .up_dn_i(up), .load_i(load),
        .load_val_i(lv), .cnt_o(d_cnt[0]), .tc_o(d_tc[0]), .co_o(d_co[0]), .wrap_o(d_wrap[0])
`ifdef SYNC_CNT_GRAY_OUT_EN
        , .cnt_gray_o(d_gray[0])
`endif
    );
    sync_cnt_param #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .RESET_VAL(0)) u_b (
        .clk_i(clk), .rst_i(rst), .en_i(en), .cin_i(cin), .up_dn_i(up), .load_i(load),
        .load_val_i(lv), .cnt_o(d_cnt[1]), .tc_o(d_tc[1]), .co_o(d_co[1]), .wrap_o(d_wrap[1])
`ifdef SYNC_CNT_GRAY_OUT_EN
        , .cnt_gray_o(d_gray[1])
`endif
    );
    sync_cnt_param #(.WIDTH(4), .MODULUS(16), .SATURATE(1), .RESET_VAL(0)) u_c (
        .clk_i(clk), .rst_i(rst), .en_i(en), .cin_i(cin), .up_dn_i(up), .load_i(load),
        .load_val_i(lv), .cnt_o(d_cnt[2]), .tc_o(d_tc[2]), .co_o(d_co[2]), .wrap_o(d_wrap[2])
`ifdef SYNC_CNT_GRAY_OUT_EN
        , .cnt_gray_o(d_gray[2])
`endif
    );
    sync_cnt_param #(.WIDTH(4)) u_lo (
        .clk_i(clk), .rst_i(rst), .en_i(en), .cin_i(cin), .up_dn_i(up), .load_i(load),
        .load_val_i(lv), .cnt_o(lo_cnt), .tc_o(lo_tc), .co_o(lo_co), .wrap_o(lo_wrap)
`ifdef SYNC_CNT_GRAY_OUT_EN
        , .cnt_gray_o(lo_gray)
`endif
    );
    sync_cnt_param #(.WIDTH(4)) u_hi (
        .clk_i(clk), .rst_i(rst), .en_i(en), .cin_i(lo_co), .up_dn_i(up), .load_i(load),
        .load_val_i(4'h0), .cnt_o(hi_cnt), .tc_o(hi_tc), .co_o(hi_co), .wrap_o(hi_wrap)
`ifdef SYNC_CNT_GRAY_OUT_EN
        , .cnt_gray_o(hi_gray)
`endif
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: plain integers; the cascade is one 8-bit counter split into nibbles.
    int mc [3];
    int mw [3];
    int cv, cwl, cwh;
    bit m_valid = 0;

    always @(negedge clk) begin
        int etc, eco, ltc, htc, lco, hco;
        if (m_valid) begin
            for (int i = 0; i < 3; i++) begin
                etc = up ? int'(mc[i] == MODS[i] - 1) : int'(mc[i] == 0);
                eco = (etc != 0 && en && cin && !load) ? 1 : 0;
                chk($sformatf("u%0d.cnt", i), int'(d_cnt[i]), mc[i]);
                chk($sformatf("u%0d.wrap", i), int'(d_wrap[i]), mw[i]);
                chk($sformatf("u%0d.tc", i), int'(d_tc[i]), etc);
                chk($sformatf("u%0d.co", i), int'(d_co[i]), eco);
`ifdef SYNC_CNT_GRAY_OUT_EN
                chk($sformatf("u%0d.gray", i), int'(d_gray[i]), mc[i] ^ (mc[i] >> 1));
`endif
            end
            ltc = up ? int'(cv % 16 == 15) : int'(cv % 16 == 0);
            htc = up ? int'(cv / 16 == 15) : int'(cv / 16 == 0);
            lco = (ltc != 0 && en && cin && !load) ? 1 : 0;
            hco = (htc != 0 && lco != 0) ? 1 : 0;
            chk("casc.val", int'({hi_cnt, lo_cnt}), cv);
            chk("casc.lo_tc", int'(lo_tc), ltc);
            chk("casc.hi_tc", int'(hi_tc), htc);
            chk("casc.lo_co", int'(lo_co), lco);
            chk("casc.hi_co", int'(hi_co), hco);
            chk("casc.lo_wrap", int'(lo_wrap), cwl);
            chk("casc.hi_wrap", int'(hi_wrap), cwh);
`ifdef SYNC_CNT_GRAY_OUT_EN
            chk("casc.lo_gray", int'(lo_gray), (cv % 16) ^ ((cv % 16) >> 1));
            chk("casc.hi_gray", int'(hi_gray), (cv / 16) ^ ((cv / 16) >> 1));
`endif
        end
        // Advance the model with the inputs the coming rising edge will sample.
        for (int i = 0; i < 3; i++) begin
            if (!rst) begin
                mc[i] = RVS[i]; mw[i] = 0;
            end else if (load) begin
                mc[i] = (int'(lv) >= MODS[i]) ? MODS[i] - 1 : int'(lv); mw[i] = 0;
            end else if (en && cin) begin
                etc = up ? int'(mc[i] == MODS[i] - 1) : int'(mc[i] == 0);
                mw[i] = etc;
                if (!(SATS[i] != 0 && etc != 0))
                    mc[i] = up ? (mc[i] + 1) % MODS[i] : (mc[i] + MODS[i] - 1) % MODS[i];
            end else begin
                mw[i] = 0;
            end
        end
        if (!rst) begin
            cv = 0; cwl = 0; cwh = 0;
        end else if (load) begin
            cv = int'(lv); cwl = 0; cwh = 0;
        end else if (en && cin) begin
            ltc = up ? int'(cv % 16 == 15) : int'(cv % 16 == 0);
            htc = up ? int'(cv / 16 == 15) : int'(cv / 16 == 0);
            cwl = ltc;
            cwh = (ltc != 0 && htc != 0) ? 1 : 0;
            cv = up ? (cv + 1) % 256 : (cv + 255) % 256;
        end else begin
            cwl = 0; cwh = 0;
        end
        if (!rst) m_valid = 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int seq_b  [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int seq_c  [5]  = '{1, 0, 0, 0, 0};
    int wrp_c  [5]  = '{0, 0, 1, 1, 1};
    int seq_cs [3]  = '{8'h0F, 8'h10, 8'h11};

    initial begin
        rst = 1'b0; en = 1'b1; cin = 1'b1; up = 1'b1; load = 1'b0; lv = 4'h0;
        tick(); tick();
        chk("reset cnt", int'(d_cnt[0]), 3);
        chk("reset wrap", int'(d_wrap[0]), 0);
        rst = 1'b1;
        tick();
        chk("step after reset", int'(d_cnt[0]), 4);

        load = 1'b1; lv = 4'd0;
        tick();
        chk("wrapup load0", int'(d_cnt[1]), 0);
        load = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk($sformatf("wrapup cnt[%0d]", i), int'(d_cnt[1]), seq_b[i]);
            chk($sformatf("wrapup wrap[%0d]", i), int'(d_wrap[1]), (i == 9) ? 1 : 0);
            chk($sformatf("wrapup tc[%0d]", i), int'(d_tc[1]), (seq_b[i] == 9) ? 1 : 0);
        end

        up = 1'b0; load = 1'b1; lv = 4'd2;
        tick();
        chk("satdn load2", int'(d_cnt[2]), 2);
        load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("satdn cnt[%0d]", i), int'(d_cnt[2]), seq_c[i]);
            chk($sformatf("satdn wrap[%0d]", i), int'(d_wrap[2]), wrp_c[i]);
        end

        up = 1'b1; en = 1'b1; load = 1'b1; lv = 4'd13;
        #1;
        chk("clamp co", int'(d_co[1]), 0);
        tick();
        chk("clamp cnt", int'(d_cnt[1]), 9);
        chk("clamp wrap", int'(d_wrap[1]), 0);
        lv = 4'd5;
        tick();
        chk("load5 cnt", int'(d_cnt[1]), 5);

        lv = 4'hE;
        tick();
        chk("casc load", int'({hi_cnt, lo_cnt}), 8'h0E);
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("casc step[%0d]", i), int'({hi_cnt, lo_cnt}), seq_cs[i]);
        end

        load = 1'b1; lv = 4'd9; rst = 1'b0;
        tick();
        chk("midrst cnt", int'(d_cnt[0]), 3);
        chk("midrst wrap", int'(d_wrap[0]), 0);
        rst = 1'b1; load = 1'b0;

`ifdef SYNC_CNT_GRAY_OUT_EN
        load = 1'b1; lv = 4'd7;
        tick();
        chk("gray at 7", int'(d_gray[0]), 4'h4);
        load = 1'b0; en = 1'b1; cin = 1'b1; up = 1'b1;
        tick();
        chk("gray cnt 8", int'(d_cnt[0]), 8);
        chk("gray at 8", int'(d_gray[0]), 4'hC);
`endif

        for (int i = 0; i < 2000; i++) begin
            rst  = ($urandom_range(31) != 0);
            load = ($urandom_range(7) == 0);
            en   = ($urandom_range(3) != 0);
            cin  = ($urandom_range(3) != 0);
            up   = 1'($urandom_range(1));
            lv   = 4'($urandom_range(15));
            tick();
        end
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
